// File: rtl/ysyx_040729_mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: FSM state encoding, requester IDs,
// round-robin preference values and the requester-to-state mapping.
package ysyx_040729_mem_arbiter_pkg;

  localparam int unsigned STATE_W  = 2;
  localparam int unsigned REQ_ID_W = 2;
  localparam int unsigned SIZE_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    GNT_IR = 2'd1,
    GNT_DR = 2'd2,
    GNT_DW = 2'd3
  } state_e;

  localparam logic [REQ_ID_W-1:0] REQ_IR = 2'd0;
  localparam logic [REQ_ID_W-1:0] REQ_DR = 2'd1;
  localparam logic [REQ_ID_W-1:0] REQ_DW = 2'd2;

  // Round-robin bit: which read requester wins a simultaneous IR/DR request.
  localparam logic RR_IR = 1'b0;
  localparam logic RR_DR = 1'b1;

  function automatic state_e grant_state(input logic [REQ_ID_W-1:0] id);
    case (id)
      REQ_DR:  return GNT_DR;
      REQ_DW:  return GNT_DW;
      default: return GNT_IR;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_040729_mem_arbiter_reg.sv
// Reg primitive: WIDTH-bit register with write enable and synchronous,
// active-high reset to RESET_VAL.
// Ports: clock, reset, wen (load enable), din (next value), dout (current value).
module ysyx_040729_mem_arbiter_reg #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clock) begin
    if (reset) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_040729_mem_arbiter.sv
// Memory arbiter: shares one memory port between I-cache refill (ir_*),
// D-cache refill (dr_*) and D-cache write-back (dw_*). Write-back has fixed
// priority; the two refills alternate by round-robin. One transaction at a
// time, never preempted; a watchdog sets sticky timeout_err on long grants.
// Ports: clock/reset (sync, active-high); ir_*/dr_*/dw_* requester ports with
// *_ready as a one-cycle done pulse; m_* memory port driven from registers;
// busy and timeout_err status.
module ysyx_040729_mem_arbiter
  import ysyx_040729_mem_arbiter_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned RW_DATA_WIDTH  = 256,
  parameter int unsigned TIMEOUT        = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  // I-cache refill
  input  logic [AXI_ADDR_WIDTH-1:0] ir_addr,
  input  logic [SIZE_W-1:0]         ir_size,
  input  logic                      ir_valid,
  output logic                      ir_ready,
  output logic [RW_DATA_WIDTH-1:0]  ir_data,
  // D-cache refill
  input  logic [AXI_ADDR_WIDTH-1:0] dr_addr,
  input  logic [SIZE_W-1:0]         dr_size,
  input  logic                      dr_valid,
  output logic                      dr_ready,
  output logic [RW_DATA_WIDTH-1:0]  dr_data,
  // D-cache write-back
  input  logic [AXI_ADDR_WIDTH-1:0] dw_addr,
  input  logic [SIZE_W-1:0]         dw_size,
  input  logic [RW_DATA_WIDTH-1:0]  dw_data,
  input  logic                      dw_valid,
  output logic                      dw_ready,
  // memory side
  output logic [AXI_ADDR_WIDTH-1:0] m_addr,
  output logic [SIZE_W-1:0]         m_size,
  output logic                      m_wen,
  output logic [RW_DATA_WIDTH-1:0]  m_wdata,
  output logic                      m_valid,
  input  logic                      m_ready,
  input  logic [RW_DATA_WIDTH-1:0]  m_rdata,
  // status
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned      CNT_W   = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_e                    state_d;
  logic [STATE_W-1:0]        state_q;
  logic                      rr_d, rr_q;
  logic [CNT_W-1:0]          cnt_d, cnt_q;
  logic                      err_d, err_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [SIZE_W-1:0]         size_d, size_q;
  logic [RW_DATA_WIDTH-1:0]  wdata_d, wdata_q;
  logic                      wen_d, wen_q;
  logic                      gnt;
  logic [REQ_ID_W-1:0]       gnt_id;

  // Grant select, next state, round-robin update, watchdog and capture mux.
  always_comb begin
    state_d = state_e'(state_q);
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    gnt_id  = REQ_IR;
    addr_d  = '0;
    size_d  = '0;
    wdata_d = '0;
    wen_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (dw_valid) begin
          gnt    = 1'b1;
          gnt_id = REQ_DW;
        end else if (ir_valid && (!dr_valid || (rr_q == RR_IR))) begin
          gnt    = 1'b1;
          gnt_id = REQ_IR;
        end else if (dr_valid) begin
          gnt    = 1'b1;
          gnt_id = REQ_DR;
        end
        if (gnt) begin
          state_d = grant_state(gnt_id);
          cnt_d   = '0;
        end
      end
      default: begin
        // Saturate so a stuck memory cannot wrap the counter back below TIMEOUT.
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (m_ready) begin
          state_d = IDLE;
          if (state_q == GNT_IR) begin
            rr_d = RR_DR;
          end else if (state_q == GNT_DR) begin
            rr_d = RR_IR;
          end
        end
      end
    endcase

    case (gnt_id)
      REQ_DW: begin
        addr_d  = dw_addr;
        size_d  = dw_size;
        wdata_d = dw_data;
        wen_d   = 1'b1;
      end
      REQ_DR: begin
        addr_d = dr_addr;
        size_d = dr_size;
      end
      default: begin
        addr_d = ir_addr;
        size_d = ir_size;
      end
    endcase

    err_d = err_q | (cnt_d == CNT_MAX);
  end

  ysyx_040729_mem_arbiter_reg #(.WIDTH(STATE_W), .RESET_VAL(IDLE)) u_state_reg (
    .clock(clock), .reset(reset), .wen(1'b1), .din(state_d), .dout(state_q)
  );

  ysyx_040729_mem_arbiter_reg #(.WIDTH(1), .RESET_VAL(RR_IR)) u_rr_reg (
    .clock(clock), .reset(reset), .wen(1'b1), .din(rr_d), .dout(rr_q)
  );

  ysyx_040729_mem_arbiter_reg #(.WIDTH(CNT_W)) u_cnt_reg (
    .clock(clock), .reset(reset), .wen(1'b1), .din(cnt_d), .dout(cnt_q)
  );

  ysyx_040729_mem_arbiter_reg #(.WIDTH(1)) u_err_reg (
    .clock(clock), .reset(reset), .wen(1'b1), .din(err_d), .dout(err_q)
  );

  // Request capture loads only on a grant, so later requester changes are ignored.
  ysyx_040729_mem_arbiter_reg #(.WIDTH(AXI_ADDR_WIDTH)) u_addr_reg (
    .clock(clock), .reset(reset), .wen(gnt), .din(addr_d), .dout(addr_q)
  );

  ysyx_040729_mem_arbiter_reg #(.WIDTH(SIZE_W)) u_size_reg (
    .clock(clock), .reset(reset), .wen(gnt), .din(size_d), .dout(size_q)
  );

  ysyx_040729_mem_arbiter_reg #(.WIDTH(RW_DATA_WIDTH)) u_wdata_reg (
    .clock(clock), .reset(reset), .wen(gnt), .din(wdata_d), .dout(wdata_q)
  );

  ysyx_040729_mem_arbiter_reg #(.WIDTH(1)) u_wen_reg (
    .clock(clock), .reset(reset), .wen(gnt), .din(wen_d), .dout(wen_q)
  );

  assign m_addr      = addr_q;
  assign m_size      = size_q;
  assign m_wdata     = wdata_q;
  assign m_wen       = wen_q;
  assign m_valid     = (state_q != IDLE);
  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;

  // Done pulses follow the memory completion only for the granted requester.
  assign ir_ready = (state_q == GNT_IR) & m_ready;
  assign dr_ready = (state_q == GNT_DR) & m_ready;
  assign dw_ready = (state_q == GNT_DW) & m_ready;
  assign ir_data  = m_rdata;
  assign dr_data  = m_rdata;

endmodule

// File: tb/tb_ysyx_040729_mem_arbiter.sv
// Directed bench for ysyx_040729_mem_arbiter (TIMEOUT = 16).
module tb_ysyx_040729_mem_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  ir_addr, dr_addr, dw_addr;
  logic [2:0]   ir_size, dr_size, dw_size;
  logic         ir_valid, dr_valid, dw_valid;
  logic         ir_ready, dr_ready, dw_ready;
  logic [255:0] ir_data, dr_data, dw_data;
  logic [31:0]  m_addr;
  logic [2:0]   m_size;
  logic         m_wen, m_valid, m_ready;
  logic [255:0] m_wdata, m_rdata;
  logic         busy, timeout_err;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] RDATA_A = {8{32'hA5A5_0001}};
  localparam logic [255:0] RDATA_B = {8{32'h1234_5678}};
  localparam logic [255:0] WDATA_W = {8{32'hDEAD_BEEF}};

  ysyx_040729_mem_arbiter #(.TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .ir_addr(ir_addr), .ir_size(ir_size), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data),
    .dr_addr(dr_addr), .dr_size(dr_size), .dr_valid(dr_valid), .dr_ready(dr_ready), .dr_data(dr_data),
    .dw_addr(dw_addr), .dw_size(dw_size), .dw_data(dw_data), .dw_valid(dw_valid), .dw_ready(dw_ready),
    .m_addr(m_addr), .m_size(m_size), .m_wen(m_wen), .m_wdata(m_wdata), .m_valid(m_valid),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    ir_addr = '0; dr_addr = '0; dw_addr = '0;
    ir_size = '0; dr_size = '0; dw_size = '0;
    ir_valid = 1'b0; dr_valid = 1'b0; dw_valid = 1'b0;
    dw_data = '0; m_ready = 1'b0; m_rdata = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_m_wen", m_wen, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_ir_ready", ir_ready, 0);

    // IR alone, completion in grant cycle 5
    ir_addr = 32'h8000_0020; ir_size = 3'd5; ir_valid = 1'b1;
    tick();
    ir_valid = 1'b0;
    check("ir_m_valid_c1", m_valid, 1);
    check("ir_m_addr", m_addr, 32'h8000_0020);
    check("ir_m_size", m_size, 3'd5);
    check("ir_m_wen", m_wen, 0);
    check("ir_busy", busy, 1);
    check("ir_ready_early", ir_ready, 0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("ir_m_valid_hold", m_valid, 1);
    end
    m_ready = 1'b1; m_rdata = RDATA_A;
    #1;
    check("ir_ready_pulse", ir_ready, 1);
    check("ir_data", ir_data, RDATA_A);
    check("ir_dr_ready_quiet", dr_ready, 0);
    tick();
    m_ready = 1'b0;
    #1;
    check("ir_idle_after", m_valid, 0);
    check("ir_ready_done", ir_ready, 0);

    // IR and DR together from reset: grants alternate IR, DR, IR, DR
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ir_addr = 32'h8000_0100; dr_addr = 32'h8000_0200; ir_size = 3'd5; dr_size = 3'd5;
    ir_valid = 1'b1; dr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_m_valid", m_valid, 1);
      check("rr_m_addr", m_addr, (i % 2 == 0) ? 32'h8000_0100 : 32'h8000_0200);
      m_ready = 1'b1; m_rdata = RDATA_B;
      #1;
      check("rr_ir_ready", ir_ready, (i % 2 == 0) ? 1 : 0);
      check("rr_dr_ready", dr_ready, (i % 2 == 0) ? 0 : 1);
      tick();
      m_ready = 1'b0;
      #1;
      check("rr_idle_gap", m_valid, 0);
    end
    ir_valid = 1'b0; dr_valid = 1'b0;

    // DW and DR together: write-back first
    dw_addr = 32'h8000_1000; dw_size = 3'd5; dw_data = WDATA_W; dw_valid = 1'b1;
    dr_addr = 32'h8000_1000; dr_size = 3'd5; dr_valid = 1'b1;
    tick();
    check("dw_m_addr", m_addr, 32'h8000_1000);
    check("dw_m_wen", m_wen, 1);
    check("dw_m_wdata", m_wdata, WDATA_W);
    m_ready = 1'b1;
    #1;
    check("dw_ready_pulse", dw_ready, 1);
    check("dw_dr_ready_quiet", dr_ready, 0);
    tick();
    m_ready = 1'b0; dw_valid = 1'b0;
    #1;
    check("dw_idle_gap", m_valid, 0);
    tick();
    check("dwdr_m_valid", m_valid, 1);
    check("dwdr_m_wen", m_wen, 0);
    check("dwdr_m_wdata", m_wdata, 0);
    m_ready = 1'b1; m_rdata = RDATA_A;
    #1;
    check("dwdr_dr_ready", dr_ready, 1);
    check("dwdr_dr_data", dr_data, RDATA_A);
    tick();
    m_ready = 1'b0; dr_valid = 1'b0;

    // DR valid dropped two cycles into the grant
    dr_addr = 32'h8000_2040; dr_valid = 1'b1;
    tick();
    check("drop_m_addr", m_addr, 32'h8000_2040);
    tick();
    tick();
    dr_valid = 1'b0; dr_addr = 32'h0000_0BAD;
    tick();
    check("drop_m_valid", m_valid, 1);
    check("drop_m_addr_held", m_addr, 32'h8000_2040);
    check("drop_dr_ready_early", dr_ready, 0);
    tick();
    m_ready = 1'b1;
    #1;
    check("drop_dr_ready", dr_ready, 1);
    tick();
    m_ready = 1'b0;
    #1;
    check("drop_dr_ready_once", dr_ready, 0);
    check("drop_idle", m_valid, 0);
    tick();
    check("drop_no_regrant", m_valid, 0);
    check("pre_timeout_clear", timeout_err, 0);

    // Watchdog: flag appears once 16 busy cycles have elapsed, stays sticky
    ir_addr = 32'h8000_3000; ir_valid = 1'b1;
    tick();
    ir_valid = 1'b0;
    for (int i = 1; i < 16; i++) tick();
    check("to_before_limit", timeout_err, 0);
    tick();
    check("to_at_limit", timeout_err, 1);
    for (int i = 0; i < 4; i++) tick();
    check("to_txn_continues", m_valid, 1);
    m_ready = 1'b1;
    #1;
    check("to_ir_ready", ir_ready, 1);
    tick();
    m_ready = 1'b0;
    #1;
    check("to_idle", m_valid, 0);
    check("to_sticky", timeout_err, 1);
    tick();
    check("to_sticky2", timeout_err, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("to_reset_clears", timeout_err, 0);

    // Reset in the middle of a write-back grant
    dw_addr = 32'h8000_4000; dw_data = WDATA_W; dw_valid = 1'b1;
    tick();
    dw_valid = 1'b0;
    check("rstdw_m_valid", m_valid, 1);
    check("rstdw_m_wen", m_wen, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstdw_m_valid_drop", m_valid, 0);
    check("rstdw_busy_drop", busy, 0);
    check("rstdw_m_wen_drop", m_wen, 0);
    m_ready = 1'b1;
    #1;
    check("rstdw_no_dw_ready", dw_ready, 0);
    check("rstdw_no_ir_ready", ir_ready, 0);
    check("rstdw_no_dr_ready", dr_ready, 0);
    tick();
    m_ready = 1'b0;
    #1;
    check("rstdw_still_idle", m_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_040729_mem_arbiter.md
YSYX_040729_MEM_ARBITER -- requirements
Module: ysyx_040729_mem_arbiter

Interface
REQ-001 SHALL take parameters: AXI_ADDR_WIDTH, default 32, address width; RW_DATA_WIDTH, default 256, line width; TIMEOUT, default 1024, watchdog limit in cycles.
REQ-002 SHALL have ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
REQ-003 SHALL have I-cache refill ports: ir_addr in AXI_ADDR_WIDTH; ir_size in 3; ir_valid in 1; ir_ready out 1 (done pulse); ir_data out RW_DATA_WIDTH.
REQ-004 SHALL have D-cache refill ports: dr_addr in AXI_ADDR_WIDTH; dr_size in 3; dr_valid in 1; dr_ready out 1; dr_data out RW_DATA_WIDTH.
REQ-005 SHALL have D-cache write-back ports: dw_addr in AXI_ADDR_WIDTH; dw_size in 3; dw_data in RW_DATA_WIDTH; dw_valid in 1; dw_ready out 1.
REQ-006 SHALL have memory ports: m_addr out AXI_ADDR_WIDTH; m_size out 3; m_wen out 1; m_wdata out RW_DATA_WIDTH; m_valid out 1; m_ready in 1 (one-cycle completion pulse); m_rdata in RW_DATA_WIDTH (valid with m_ready).
REQ-007 SHALL have status ports: busy out 1; timeout_err out 1 (sticky).

Function
REQ-008 SHALL implement states IDLE, GNT_IR, GNT_DR, GNT_DW; one outstanding memory transaction at most.
REQ-009 In IDLE, grant priority SHALL be dw_valid first, then ir/dr by round-robin; rr bit selects the preferred read requester.
REQ-010 rr SHALL switch to DR after an IR completion and to IR after a DR completion; DW completion SHALL leave rr unchanged; reset value: IR preferred.
REQ-011 On grant, addr, size, wdata and wen (1 only for DW) SHALL be captured into registers; m_* outputs SHALL be driven only from these registers; the state SHALL move to GNT_x on the next edge.
REQ-012 m_valid SHALL be 1 exactly while the state is not IDLE; first m_valid is one cycle after the requester valid is sampled in IDLE.
REQ-013 The grant SHALL NOT be preempted; requester inputs SHALL be ignored while granted, and deasserting valid SHALL NOT abort the transaction.
REQ-014 In GNT_x, x_ready = m_ready combinationally; other *_ready SHALL be 0; ir_data = dr_data = m_rdata unconditionally.
REQ-015 On m_ready, the state SHALL return to IDLE on the next edge; at least one IDLE cycle SHALL separate transactions; m_ready in IDLE SHALL be ignored.
REQ-016 DR and DW both pending in IDLE SHALL grant DW first, so a write-back precedes the refill for the same set.
REQ-017 busy = (state != IDLE).
REQ-018 A saturating cycle counter (clog2(TIMEOUT)+1 bits) SHALL clear on every grant and increment each non-IDLE cycle; reaching TIMEOUT SHALL set timeout_err; the transaction SHALL continue.

Reset
REQ-019 Reset SHALL force: state IDLE, rr=IR, counter 0, timeout_err 0, captured regs 0; all *_ready, m_valid, m_wen, busy = 0 in the cycle after reset is sampled.
REQ-020 Reset during a grant SHALL drop m_valid on the next edge; a later m_ready SHALL be ignored.

Structure
REQ-021 State encodings and requester IDs (IR=0, DR=1, DW=2) SHALL be constants in the shared core package.
REQ-022 Registers SHALL use the codebase Reg primitive; no sub-module beyond it is required; the grant-select logic SHALL stay inline.

Verification
REQ-023 The bench SHALL cover:
- ir_valid alone, addr 0x80000020, m_ready after 5 cycles -> m_valid at cycle 1, m_addr 0x80000020, m_wen 0, ir_ready one pulse with ir_data = m_rdata, IDLE next cycle.
- ir_valid and dr_valid together after reset -> IR granted first, then DR after one IDLE cycle; repeated 4x -> grants alternate IR, DR, IR, DR.
- dw_valid and dr_valid together, dw_addr 0x80001000 -> DW first with m_wen 1, m_wdata = dw_data; DR second with m_wen 0.
- dr_valid dropped 2 cycles after grant -> m_valid held, m_addr unchanged until m_ready, dr_ready pulses once.
- TIMEOUT=16, m_ready withheld 20 cycles -> timeout_err rises at cycle 16 of the grant, stays 1 after completion until reset.
- reset asserted mid-GNT_DW -> m_valid and busy 0 next cycle; a following m_ready produces no *_ready pulse.
